// File: rtl/dual_grant_decoder.sv
// dual_grant_decoder: decodes up to two issue indices per cycle into grant pulses
// and keeps each granted slot busy for a programmable number of cycles.
module dual_grant_decoder #(
  parameter int REQ_N = 12,
  parameter int OUT_N = $clog2(REQ_N),
  parameter int LAT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [OUT_N-1:0] i_data_1,
  input  logic             i_1_valid,
  input  logic [OUT_N-1:0] i_data_2,
  input  logic             i_2_valid,
  input  logic [LAT_W-1:0] i_lat,
  output logic [REQ_N-1:0] o_grant,
  output logic [REQ_N-1:0] o_busy,
  output logic [REQ_N-1:0] o_done,
  output logic [OUT_N:0]   o_busy_cnt,
  output logic             o_err
);
  logic [REQ_N-1:0] dec_1, dec_2, grant_n, busy_n, done_n;
  logic [LAT_W-1:0] cnt_q [REQ_N];
  logic [LAT_W-1:0] cnt_n [REQ_N];
  logic [LAT_W-1:0] lat;
  logic [OUT_N:0]   busy_cnt_n;
  logic             acc_1, acc_2, err_n;
  // Out-of-range indices decode to all-zero, which is what rejects them.
  always_comb begin
    for (int s = 0; s < REQ_N; s++) begin
      dec_1[s] = i_data_1 == OUT_N'(s);
      dec_2[s] = i_data_2 == OUT_N'(s);
    end
    lat = (i_lat == '0) ? LAT_W'(1) : i_lat;
    acc_1 = i_1_valid && |dec_1 && !(|(dec_1 & o_busy));
    acc_2 = i_2_valid && |dec_2 && !(|(dec_2 & o_busy)) && !(i_1_valid && i_data_2 == i_data_1);
    err_n = (i_1_valid && !acc_1) || (i_2_valid && !acc_2);
    grant_n = (acc_1 ? dec_1 : '0) | (acc_2 ? dec_2 : '0);
    busy_cnt_n = '0;
    for (int s = 0; s < REQ_N; s++) begin
      done_n[s] = o_busy[s] && cnt_q[s] == LAT_W'(1);
      busy_n[s] = grant_n[s] || (o_busy[s] && !done_n[s]);
      cnt_n[s] = grant_n[s] ? lat : done_n[s] ? '0 : o_busy[s] ? cnt_q[s] - LAT_W'(1) : cnt_q[s];
      busy_cnt_n = busy_cnt_n + (OUT_N+1)'(busy_n[s]);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_grant <= '0;
      o_busy <= '0;
      o_done <= '0;
      o_busy_cnt <= '0;
      o_err <= 1'b0;
      cnt_q <= '{default: '0};
    end else begin
      o_grant <= grant_n;
      o_busy <= busy_n;
      o_done <= done_n;
      o_busy_cnt <= busy_cnt_n;
      o_err <= err_n;
      cnt_q <= cnt_n;
    end
endmodule

// File: tb/tb_dual_grant_decoder.sv
// tb_dual_grant_decoder: directed scenarios plus randomized issues checked
// against a remaining-cycles-per-slot reference model.
module tb_dual_grant_decoder;
  localparam int N = 12;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] d1 = '0, d2 = '0, lat = '0;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [N-1:0] grant, busy, done;
  logic [4:0] busy_cnt;
  logic err;
  int checks = 0, failures = 0;
  int rem [N];
  logic [N-1:0] e_grant, e_done;
  logic e_err;

  dual_grant_decoder dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data_1(d1), .i_1_valid(v1), .i_data_2(d2), .i_2_valid(v2), .i_lat(lat),
    .o_grant(grant), .o_busy(busy), .o_done(done), .o_busy_cnt(busy_cnt), .o_err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] e_busy();
    for (int s = 0; s < N; s++) e_busy[s] = rem[s] > 0;
  endfunction

  function automatic int e_cnt();
    e_cnt = 0;
    for (int s = 0; s < N; s++) e_cnt += (rem[s] > 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < N; s++) rem[s] = 0;
    e_grant = '0;
    e_done = '0;
    e_err = 1'b0;
  endtask

  // Drive one cycle of issues, advance the model, and land on the next negedge.
  task automatic cycle(input bit a_v1, input int a_d1, input bit a_v2, input int a_d2, input int a_lat);
    bit a1, a2;
    v1 = a_v1; d1 = 4'(a_d1); v2 = a_v2; d2 = 4'(a_d2); lat = 4'(a_lat);
    a1 = a_v1 && a_d1 < N && rem[a_d1] == 0;
    a2 = a_v2 && a_d2 < N && rem[a_d2] == 0 && !(a_v1 && a_d2 == a_d1);
    e_err = (a_v1 && !a1) || (a_v2 && !a2);
    e_grant = '0;
    e_done = '0;
    for (int s = 0; s < N; s++)
      if (rem[s] > 0) begin
        rem[s]--;
        if (rem[s] == 0) e_done[s] = 1'b1;
      end
    if (a1) begin rem[a_d1] = a_lat == 0 ? 1 : a_lat; e_grant[a_d1] = 1'b1; end
    if (a2) begin rem[a_d2] = a_lat == 0 ? 1 : a_lat; e_grant[a_d2] = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0; v2 = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if ({grant, busy, done, busy_cnt, err} !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got g=%h b=%h d=%h c=%0d e=%b want all 0", i, grant, busy, done, busy_cnt, err);
      end
    end
  endtask

  task automatic test_single();
    cycle(1, 3, 0, 0, 4);
    checks++;
    if (grant !== 12'h008 || busy !== 12'h008 || busy_cnt !== 5'd1) begin
      failures++;
      $display("FAIL single_issue got g=%h b=%h c=%0d want g=008 b=008 c=1", grant, busy, busy_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (grant !== '0 || busy !== 12'h008 || done !== '0) begin
        failures++;
        $display("FAIL single_hold cyc=%0d got g=%h b=%h d=%h want g=000 b=008 d=000", i, grant, busy, done);
      end
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (done !== 12'h008 || busy !== '0 || busy_cnt !== 5'd0) begin
      failures++;
      $display("FAIL single_done got d=%h b=%h c=%0d want d=008 b=000 c=0", done, busy, busy_cnt);
    end
  endtask

  task automatic test_dual();
    cycle(1, 0, 1, 11, 0);
    checks++;
    if (grant !== 12'h801 || busy !== 12'h801 || err !== 1'b0 || busy_cnt !== 5'd2) begin
      failures++;
      $display("FAIL dual_issue got g=%h b=%h e=%b c=%0d want g=801 b=801 e=0 c=2", grant, busy, err, busy_cnt);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (done !== 12'h801 || busy !== '0 || grant !== '0) begin
      failures++;
      $display("FAIL dual_done got d=%h b=%h g=%h want d=801 b=000 g=000", done, busy, grant);
    end
  endtask

  task automatic test_tie();
    cycle(1, 5, 1, 5, 2);
    checks++;
    if (grant !== 12'h020 || err !== 1'b1) begin
      failures++;
      $display("FAIL tie_issue got g=%h e=%b want g=020 e=1", grant, err);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b0 || busy !== 12'h020 || done !== '0) begin
      failures++;
      $display("FAIL tie_hold got e=%b b=%h d=%h want e=0 b=020 d=000", err, busy, done);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (done !== 12'h020 || busy !== '0) begin
      failures++;
      $display("FAIL tie_release got d=%h b=%h want d=020 b=000", done, busy);
    end
  endtask

  task automatic test_final_cycle();
    cycle(1, 7, 0, 0, 2);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 7, 3);
    checks++;
    if (err !== 1'b1 || grant !== '0 || done !== 12'h080 || busy !== '0) begin
      failures++;
      $display("FAIL final_cycle_reject got e=%b g=%h d=%h b=%h want e=1 g=000 d=080 b=000", err, grant, done, busy);
    end
    cycle(1, 7, 0, 0, 1);
    checks++;
    if (grant !== 12'h080 || err !== 1'b0 || busy !== 12'h080) begin
      failures++;
      $display("FAIL done_cycle_reissue got g=%h e=%b b=%h want g=080 e=0 b=080", grant, err, busy);
    end
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_range_fill_reset();
    cycle(1, 2, 1, 13, 5);
    checks++;
    if (grant !== 12'h004 || err !== 1'b1) begin
      failures++;
      $display("FAIL out_of_range got g=%h e=%b want g=004 e=1", grant, err);
    end
    repeat (6) cycle(0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cycle(1, 2 * k, 1, 2 * k + 1, 15);
    checks++;
    if (busy_cnt !== 5'd12 || busy !== 12'hfff) begin
      failures++;
      $display("FAIL fill_all got c=%0d b=%h want c=12 b=fff", busy_cnt, busy);
    end
    cycle(1, 4, 0, 0, 3);
    checks++;
    if (err !== 1'b1 || grant !== '0) begin
      failures++;
      $display("FAIL full_reject got e=%b g=%h want e=1 g=000", err, grant);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({grant, busy, done, busy_cnt, err} !== '0) begin
      failures++;
      $display("FAIL async_reset got g=%h b=%h d=%h c=%0d e=%b want all 0", grant, busy, done, busy_cnt, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (done !== '0 || busy !== '0) begin
      failures++;
      $display("FAIL reset_no_done got d=%h b=%h want d=000 b=000", done, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 13), $urandom_range(0, 3) != 0,
            $urandom_range(0, 13), $urandom_range(0, 6));
      checks++;
      if (grant !== e_grant || busy !== e_busy() || done !== e_done || busy_cnt !== 5'(e_cnt()) || err !== e_err) begin
        failures++;
        $display("FAIL random cyc=%0d got g=%h b=%h d=%h c=%0d e=%b want g=%h b=%h d=%h c=%0d e=%b",
                 i, grant, busy, done, busy_cnt, err, e_grant, e_busy(), e_done, e_cnt(), e_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_tie();
    test_final_cycle();
    test_range_fill_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
